// File: rtl/stage_wb_arb_if.sv
// Producer-side write-back bus for stage_wb_arb: per-source valid/ready handshake and result fields.
interface stage_wb_arb_if #(
  parameter int NUM_SRC  = 3,
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
);
  logic [NUM_SRC-1:0]               src_valid;
  logic [NUM_SRC-1:0]               src_ready;
  logic [NUM_SRC-1:0]               src_reg_write;
  logic [NUM_SRC-1:0][4:0]          src_rd_addr;
  logic [NUM_SRC-1:0][1:0]          src_wb_src;
  logic [NUM_SRC-1:0][XLEN-1:0]     src_alu_result;
  logic [NUM_SRC-1:0][XLEN-1:0]     src_mem_data;
  logic [NUM_SRC-1:0][PC_WIDTH-1:0] src_pc_plus_4;

  modport master (
    output src_valid, src_reg_write, src_rd_addr, src_wb_src,
           src_alu_result, src_mem_data, src_pc_plus_4,
    input  src_ready
  );

  modport slave (
    input  src_valid, src_reg_write, src_rd_addr, src_wb_src,
           src_alu_result, src_mem_data, src_pc_plus_4,
    output src_ready
  );
endinterface

// File: rtl/stage_wb_arb.sv
// Multi-source write-back arbiter: per-source FIFOs drained one entry per cycle into the register file.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module stage_wb_arb #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32,
  parameter int NUM_SRC  = 3,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  stage_wb_arb_if.slave     src,
  input  logic              flush,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              busy,
  output logic [31:0]       rd_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // wb_src encodings, matching riscv_pkg::wb_src_e
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  logic [NUM_SRC-1:0]           empty;
  logic [NUM_SRC-1:0]           full;
  logic [NUM_SRC-1:0]           pop;
  logic [NUM_SRC-1:0][XLEN-1:0] head_data;
  logic [NUM_SRC-1:0][4:0]      head_rd;
  logic [NUM_SRC-1:0][31:0]     pend_src;

  logic                         grant_valid;
  logic [GW-1:0]                grant_idx;

  logic                         rf_wen_reg;
  logic [4:0]                   rf_waddr_reg;
  logic [XLEN-1:0]              rf_wdata_reg;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [PW-1:0]       wr_ptr_reg;
      logic [PW-1:0]       rd_ptr_reg;
      logic [XLEN-1:0]     data_mem [DEPTH];
      logic [4:0]          rd_mem   [DEPTH];
      logic                accept;
      logic                enq;
      logic [PC_WIDTH-1:0] pc4;
      logic [XLEN-1:0]     sel_data;
      logic [31:0]         pend;

      assign full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);

      assign src.src_ready[gi] = !full[gi] && !flush && rst_n;
      assign accept = src.src_valid[gi] && src.src_ready[gi];
      // Results that write nothing are consumed here and never occupy a slot
      assign enq    = accept && src.src_reg_write[gi] && (src.src_rd_addr[gi] != 5'd0);
      assign pc4    = src.src_pc_plus_4[gi];
      assign pop[gi] = grant_valid && !flush && (grant_idx == GW'(gi));

      always_comb begin
        case (src.src_wb_src[gi])
          WB_MEM:  sel_data = src.src_mem_data[gi];
          WB_PC4:  sel_data = XLEN'(pc4);
          default: sel_data = src.src_alu_result[gi];
        endcase
      end

      always_ff @(posedge clk) begin
        if (enq) begin
          data_mem[wr_ptr_reg[AW-1:0]] <= sel_data;
          rd_mem[wr_ptr_reg[AW-1:0]]   <= src.src_rd_addr[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (enq)     wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      assign head_data[gi] = data_mem[rd_ptr_reg[AW-1:0]];
      assign head_rd[gi]   = rd_mem[rd_ptr_reg[AW-1:0]];

      // An entry is live when its distance from the read pointer is below the occupancy
      always_comb begin
        logic [PW-1:0] count;
        logic [AW-1:0] offset;
        pend   = '0;
        count  = wr_ptr_reg - rd_ptr_reg;
        offset = '0;
        for (int j = 0; j < DEPTH; j++) begin
          offset = AW'(j) - rd_ptr_reg[AW-1:0];
          if ({1'b0, offset} < count) pend[rd_mem[j]] = 1'b1;
        end
      end
      assign pend_src[gi] = pend;
    end
  endgenerate

`ifdef WB_ARB_RR_EN
  logic [GW-1:0] last_reg;

  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = last_reg;
    idx         = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_reg) + k) % NUM_SRC;
      if (!grant_valid && !empty[GW'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg <= GW'(NUM_SRC - 1);
    end else if (grant_valid && !flush) begin
      last_reg <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (!empty[k]) begin
        grant_valid = 1'b1;
        grant_idx   = GW'(k);
      end
    end
  end
`endif

  // Address/data hold their last value when nothing is written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen_reg   <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else if (flush) begin
      rf_wen_reg   <= 1'b0;
    end else if (grant_valid) begin
      rf_wen_reg   <= 1'b1;
      rf_waddr_reg <= head_rd[grant_idx];
      rf_wdata_reg <= head_data[grant_idx];
    end else begin
      rf_wen_reg   <= 1'b0;
    end
  end

  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < NUM_SRC; i++) rd_pending = rd_pending | pend_src[i];
    if (rf_wen_reg) rd_pending[rf_waddr_reg] = 1'b1;
    rd_pending[0] = 1'b0;
  end

  assign busy     = (|(~empty)) || rf_wen_reg;
  assign rf_wen   = rf_wen_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
endmodule

// File: tb/tb_stage_wb_arb.sv
// Bench for stage_wb_arb: table-driven single writes, then scoreboarded streaming, arbitration, flush and reset.
module tb_stage_wb_arb;
  localparam int NS    = 3;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int PCW   = 20;

  typedef struct {
    logic            rw;
    logic [4:0]      rd;
    logic [1:0]      ws;
    logic [31:0]     alu;
    logic [31:0]     mem;
    logic [PCW-1:0]  pc;
  } item_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          src;
    item_t       it;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic [31:0] rd_pending;

  always #5 clk = ~clk;

  stage_wb_arb_if #(.NUM_SRC(NS), .XLEN(XLEN), .PC_WIDTH(PCW)) bus ();

  stage_wb_arb #(.XLEN(XLEN), .PC_WIDTH(PCW), .NUM_SRC(NS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src        (bus),
    .flush      (flush),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .rd_pending (rd_pending)
  );

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  int          nwrites = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic [NS-1:0] saw_block = '0;
  item_t       stim_q [NS][$];
  exp_t        exp_q  [NS][$];
  int          log_q  [$];
  vec_t        vecs   [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] sel_data(input item_t it);
    case (it.ws)
      2'd1:    return it.mem;
      2'd2:    return {{(32-PCW){1'b0}}, it.pc};
      default: return it.alu;
    endcase
  endfunction

  function automatic item_t mk_item(input logic rw, input logic [4:0] rd, input logic [1:0] ws,
                                    input logic [31:0] alu, input logic [31:0] mem,
                                    input logic [PCW-1:0] pc);
    item_t it;
    it.rw = rw; it.rd = rd; it.ws = ws; it.alu = alu; it.mem = mem; it.pc = pc;
    return it;
  endfunction

  function automatic item_t stream_item(input int s, input int n);
    return mk_item(1'b1, 5'(s * 10 + n + 1), 2'(n % 3),
                   {4'hA, 4'(s), 8'(n), 16'h0001},
                   {4'hB, 4'(s), 8'(n), 16'h0002},
                   {4'(s), 8'(n), 8'h44});
  endfunction

  function automatic vec_t mk_vec(input int s, input item_t it, input logic wen,
                                  input logic [4:0] addr, input logic [31:0] data);
    vec_t v;
    v.src = s; v.it = it; v.wen = wen; v.addr = addr; v.data = data;
    return v;
  endfunction

  function automatic bit all_idle();
    for (int s = 0; s < NS; s++)
      if (stim_q[s].size() != 0 || exp_q[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_queues();
    for (int s = 0; s < NS; s++) begin
      stim_q[s].delete();
      exp_q[s].delete();
    end
    bus.src_valid = '0;
  endtask

  // One clock: drive at +1 after the edge, observe/score at the falling edge, accept at the next edge
  task automatic step(input bit fl, input bit rs);
    logic [NS-1:0] drv;
    logic [NS-1:0] req_ready;
    logic [31:0]   req_pend;
    bit            wrote;
    int            found;
    item_t         it;
    exp_t          e;
    drv   = '0;
    rst_n = !rs;
    flush = fl;
    for (int s = 0; s < NS; s++) begin
      if (stim_q[s].size() > 0) begin
        drv[s] = 1'b1;
        bus.src_valid[s]      = 1'b1;
        bus.src_reg_write[s]  = stim_q[s][0].rw;
        bus.src_rd_addr[s]    = stim_q[s][0].rd;
        bus.src_wb_src[s]     = stim_q[s][0].ws;
        bus.src_alu_result[s] = stim_q[s][0].alu;
        bus.src_mem_data[s]   = stim_q[s][0].mem;
        bus.src_pc_plus_4[s]  = stim_q[s][0].pc;
      end else begin
        bus.src_valid[s] = 1'b0;
      end
    end
    @(negedge clk);
    if (mon_en) begin
      wrote    = 0;
      req_pend = '0;
      if (rf_wen === 1'b1) begin
        found = -1;
        for (int s = 0; s < NS; s++)
          if (found < 0 && exp_q[s].size() > 0 &&
              exp_q[s][0].rd == rf_waddr && exp_q[s][0].data == rf_wdata) found = s;
        checks++;
        if (found < 0) begin
          errors++;
          $display("FAIL wb_write: got rd=%0d data=0x%08h, required a queued head entry", rf_waddr, rf_wdata);
        end else begin
          e = exp_q[found].pop_front();
          log_q.push_back(found);
          nwrites++;
          wrote     = 1;
          req_pend[e.rd] = 1'b1;
          last_addr = e.rd;
          last_data = e.data;
          $display("wb write src%0d rd=%0d data=0x%08h", found, e.rd, e.data);
        end
      end else begin
        chk("rf_wen_idle", {31'd0, rf_wen}, 32'd0);
        chk("rf_waddr_hold", {27'd0, rf_waddr}, {27'd0, last_addr});
        chk("rf_wdata_hold", rf_wdata, last_data);
      end
      req_ready = '0;
      for (int s = 0; s < NS; s++) begin
        foreach (exp_q[s][k]) req_pend[exp_q[s][k].rd] = 1'b1;
        req_ready[s] = !fl && !rs && (exp_q[s].size() < DEPTH);
        if (exp_q[s].size() != 0) wrote = 1;
      end
      chk("rd_pending", rd_pending, req_pend);
      chk("busy", {31'd0, busy}, {31'd0, wrote});
      chk("src_ready", {29'd0, bus.src_ready}, {29'd0, req_ready});
      for (int s = 0; s < NS; s++) begin
        if (drv[s] && !bus.src_ready[s]) saw_block[s] = 1'b1;
        if (drv[s] && bus.src_ready[s]) begin
          it = stim_q[s].pop_front();
          if (it.rw && it.rd != 5'd0) begin
            e.rd = it.rd;
            e.data = sel_data(it);
            exp_q[s].push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (fl || rs) clear_queues();
    if (rs) begin
      last_addr = '0;
      last_data = '0;
    end
  endtask

  task automatic do_reset();
    step(0, 1);
    log_q.delete();
    nwrites   = 0;
    saw_block = '0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    bit done;
    done = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      if (all_idle()) done = 1;
      else step(0, 0);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got still busy after %0d cycles, required drained", name, max_cycles);
    end
  endtask

  initial begin
    bus.src_valid = '0; bus.src_reg_write = '0; bus.src_rd_addr = '0; bus.src_wb_src = '0;
    bus.src_alu_result = '0; bus.src_mem_data = '0; bus.src_pc_plus_4 = '0;

    vecs[0] = mk_vec(0, mk_item(1, 5'd5,  2'd0, 32'h1234_5678, 32'hAAAA_0000, 20'h00010), 1, 5'd5,  32'h1234_5678);
    vecs[1] = mk_vec(1, mk_item(1, 5'd3,  2'd2, 32'h1111_0000, 32'h2222_0000, 20'h00104), 1, 5'd3,  32'h0000_0104);
    vecs[2] = mk_vec(2, mk_item(1, 5'd9,  2'd1, 32'h3333_0000, 32'hDEAD_BEEF, 20'h00200), 1, 5'd9,  32'hDEAD_BEEF);
    vecs[3] = mk_vec(0, mk_item(1, 5'd0,  2'd1, 32'h4444_0000, 32'h5555_0000, 20'h00000), 0, 5'd0,  32'h0);
    vecs[4] = mk_vec(1, mk_item(0, 5'd7,  2'd0, 32'h6666_0000, 32'h7777_0000, 20'h00000), 0, 5'd0,  32'h0);
    vecs[5] = mk_vec(2, mk_item(1, 5'd31, 2'd3, 32'h8888_0001, 32'h9999_0000, 20'h00300), 1, 5'd31, 32'h8888_0001);
    vecs[6] = mk_vec(0, mk_item(1, 5'd1,  2'd2, 32'hCAFE_0000, 32'hBEEF_0000, 20'hFFFFC), 1, 5'd1,  32'h000F_FFFC);

    // Reset: first edge brings state out of X, then reset values are scored
    step(0, 1);
    mon_en = 1;
    do_reset();
    chk("reset_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rd_pending", rd_pending, 32'd0);

    // Single results: accept, write two edges later, then idle
    for (int v = 0; v < 7; v++) begin
      stim_q[vecs[v].src].push_back(vecs[v].it);
      step(0, 0);
      chk($sformatf("v%0d_pend_accept", v), {31'd0, rd_pending[vecs[v].it.rd]}, {31'd0, vecs[v].wen});
      step(0, 0);
      chk($sformatf("v%0d_rf_wen", v), {31'd0, rf_wen}, {31'd0, vecs[v].wen});
      if (vecs[v].wen) begin
        chk($sformatf("v%0d_rf_waddr", v), {27'd0, rf_waddr}, {27'd0, vecs[v].addr});
        chk($sformatf("v%0d_rf_wdata", v), rf_wdata, vecs[v].data);
        chk($sformatf("v%0d_pend_write", v), rd_pending, 32'd1 << vecs[v].addr);
      end
      step(0, 0);
      chk($sformatf("v%0d_wen_after", v), {31'd0, rf_wen}, 32'd0);
      chk($sformatf("v%0d_busy_after", v), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_pend_after", v), rd_pending, 32'd0);
    end

    // Backpressure: source 2 offers 4 results against two busy neighbours
    do_reset();
    for (int n = 0; n < 2; n++) stim_q[0].push_back(stream_item(0, n));
    for (int n = 0; n < 2; n++) stim_q[1].push_back(stream_item(1, n));
    for (int n = 0; n < 4; n++) stim_q[2].push_back(stream_item(2, n));
    drain("full", 60);
    chk("full_src2_blocked", {31'd0, saw_block[2]}, 32'd1);
    chk("full_write_count", nwrites, 32'd8);

    // Arbitration with all sources continuously valid
    do_reset();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < 6; n++) stim_q[s].push_back(stream_item(s, n));
    drain("arb", 100);
    chk("arb_write_count", log_q.size(), 32'd18);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
`ifdef WB_ARB_RR_EN
      chk($sformatf("arb_grant%0d", i), log_q[i], i % NS);
`else
      chk($sformatf("arb_grant%0d", i), log_q[i], 32'd0);
`endif
    end

    // Flush with all FIFOs loaded and a push offered during the flush cycle
    do_reset();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < 3; n++) stim_q[s].push_back(stream_item(s, n));
    step(0, 0);
    step(0, 0);
    step(1, 0);
    chk("flush_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_rd_pending", rd_pending, 32'd0);
    nwrites = 0;
    for (int c = 0; c < 4; c++) step(0, 0);
    chk("flush_no_writes", nwrites, 32'd0);

    // Reset mid-stream with entries still queued
    do_reset();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < 4; n++) stim_q[s].push_back(stream_item(s, n));
    step(0, 0);
    step(0, 0);
    step(0, 1);
    chk("midrst_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("midrst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("midrst_rf_wdata", rf_wdata, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rd_pending", rd_pending, 32'd0);
    nwrites = 0;
    for (int c = 0; c < 4; c++) step(0, 0);
    chk("midrst_no_writes", nwrites, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
